// File: rtl/dm_arbiter_if.sv
// Bus bundle between the M stage, the external loader/debug port and the data memory.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dm_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_stall;

  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wd;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  logic [1:0]  owner;
  logic [15:0] conflict_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  ext_req, ext_we, ext_addr, ext_wd,
    input  dm_rd,
    output cpu_rd, cpu_stall,
    output ext_gnt, ext_rvalid, ext_rdata,
    output dm_we, dm_addr, dm_wd,
    output owner, conflict_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    output ext_req, ext_we, ext_addr, ext_wd,
    output dm_rd,
    input  cpu_rd, cpu_stall,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  dm_we, dm_addr, dm_wd,
    input  owner, conflict_cnt
  );
endinterface

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: the CPU M stage wins by default, and the external
// port is forced one grant after STARVE_MAX consecutive ungranted request cycles.
module dm_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  localparam logic [1:0]  OWN_IDLE   = 2'b00;
  localparam logic [1:0]  OWN_CPU    = 2'b01;
  localparam logic [1:0]  OWN_EXT    = 2'b10;
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [15:0] CNT_SAT    = 16'hFFFF;

  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  logic        cpu_gnt;
  logic        ext_gnt_c;
  logic [1:0]  owner_next;
  logic        rvalid_next;
  logic [31:0] rdata_next;
  logic [15:0] conflict_next;

  // Grant decision; reset suppresses every grant so nothing reaches the memory
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt_c = 1'b0;
    if (reset) begin
      cpu_gnt   = 1'b0;
      ext_gnt_c = 1'b0;
    end else if (bus.ext_req && (!bus.cpu_req || (starve_cnt == STARVE_LIM))) begin
      ext_gnt_c = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_gnt = 1'b1;
    end else begin
      cpu_gnt   = 1'b0;
      ext_gnt_c = 1'b0;
    end
  end

  // Owner mux towards the memory plus the combinational handshake outputs
  always_comb begin
    bus.ext_gnt   = ext_gnt_c;
    bus.cpu_stall = bus.cpu_req && !cpu_gnt && !reset;
    bus.cpu_rd    = bus.dm_rd;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = bus.cpu_addr;
    bus.dm_wd     = bus.cpu_wd;
    if (ext_gnt_c) begin
      bus.dm_we   = bus.ext_we;
      bus.dm_addr = bus.ext_addr;
      bus.dm_wd   = bus.ext_wd;
    end else if (cpu_gnt) begin
      bus.dm_we   = bus.cpu_we;
      bus.dm_addr = bus.cpu_addr;
      bus.dm_wd   = bus.cpu_wd;
    end else begin
      bus.dm_we   = 1'b0;
      bus.dm_addr = bus.cpu_addr;
      bus.dm_wd   = bus.cpu_wd;
    end
  end

  // Next values for the starvation counter, owner, ext read-back and stall counter
  always_comb begin
    starve_next   = 4'd0;
    owner_next    = OWN_IDLE;
    rvalid_next   = ext_gnt_c && !bus.ext_we;
    rdata_next    = bus.ext_rdata;
    conflict_next = bus.conflict_cnt;

    if (bus.ext_req && !ext_gnt_c) begin
      if (starve_cnt >= STARVE_LIM) begin
        starve_next = STARVE_LIM;
      end else begin
        starve_next = starve_cnt + 4'd1;
      end
    end else begin
      starve_next = 4'd0;
    end

    case ({ext_gnt_c, cpu_gnt})
      2'b10:   owner_next = OWN_EXT;
      2'b01:   owner_next = OWN_CPU;
      default: owner_next = OWN_IDLE;
    endcase

    if (rvalid_next) begin
      rdata_next = bus.dm_rd;
    end else begin
      rdata_next = bus.ext_rdata;
    end

    // Assigned every cycle so the counter always reflects its own current value
    if (bus.cpu_stall && (bus.conflict_cnt != CNT_SAT)) begin
      conflict_next = bus.conflict_cnt + 16'd1;
    end else begin
      conflict_next = bus.conflict_cnt;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt       <= 4'd0;
      bus.owner        <= OWN_IDLE;
      bus.ext_rvalid   <= 1'b0;
      bus.ext_rdata    <= 32'd0;
      bus.conflict_cnt <= 16'd0;
    end else begin
      starve_cnt       <= starve_next;
      bus.owner        <= owner_next;
      bus.ext_rvalid   <= rvalid_next;
      bus.ext_rdata    <= rdata_next;
      bus.conflict_cnt <= conflict_next;
    end
  end

endmodule
